// File: rtl/mcpu_pkg.sv
// Shared definitions for the mcpu core: opcodes, FSM state encoding, field helpers.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package mcpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_XOR = 4'h8, OP_NOT = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB,
    OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPND   = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam int OPC_W = 4;

  // Bits needed to name one of nregs registers.
  function automatic int reg_idx_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  // LSB of the rd field: it sits directly below the opcode.
  function automatic int rd_lsb(input int width, input int nregs);
    return width - OPC_W - reg_idx_w(nregs);
  endfunction

  // LSB of the rs field: it sits directly below rd.
  function automatic int rs_lsb(input int width, input int nregs);
    return rd_lsb(width, nregs) - reg_idx_w(nregs);
  endfunction

  // Opcodes followed by an operand word (immediate or address).
  function automatic logic is_two_word(input opcode_e op);
    return (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) ||
           (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
  endfunction

endpackage

// File: rtl/mcpu_if.sv
// Split memory bus between the core (master) and a single-port RAM (slave).
// Latency: combinational wires only.
// Backpressure: slave stretches an access by holding mem_ready low.
interface mcpu_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rd_n;
  logic             mem_wr_n;
  logic             mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_rd_n, mem_wr_n,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd_n, mem_wr_n,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mcpu_alu.sv
// Combinational ALU for the mcpu core: result plus zero and carry/borrow flags.
// Latency: 0 cycles.
// Backpressure: none; non-ALU opcodes pass a and c_in straight through.
module mcpu_alu import mcpu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  opcode_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c
);

  logic [WIDTH:0] w_sum;

  // Compute the result and flags for the selected operation.
  always_comb begin
    w_sum  = '0;
    result = a;
    c      = c_in;
    case (op)
      OP_ADD: begin
        w_sum  = {1'b0, a} + {1'b0, b};
        result = w_sum[WIDTH-1:0];
        c      = w_sum[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit is set exactly when a < b (borrow).
        w_sum  = {1'b0, a} - {1'b0, b};
        result = w_sum[WIDTH-1:0];
        c      = w_sum[WIDTH];
      end
      OP_AND: begin result = a & b; c = 1'b0; end
      OP_OR:  begin result = a | b; c = 1'b0; end
      OP_XOR: begin result = a ^ b; c = 1'b0; end
      OP_NOT: begin result = ~a;    c = 1'b0; end
      OP_SHL: begin result = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
      OP_SHR: begin result = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
      default: begin result = a; c = c_in; end
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/mcpu_core.sv
// Multi-cycle accumulator/register CPU core; optional single-step control via MCPU_STEP_EN.
// Latency: NOP 2, ALU 3, LDI/JMP 3, LD/ST 4 cycles with zero wait states.
// Backpressure: every access holds addr/wdata/strobe until mem_ready=1; rst abandons it.
module mcpu_core import mcpu_pkg::*; #(
  parameter int               WIDTH    = 8,
  parameter int               NREGS    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MCPU_STEP_EN
  input  logic             run,
  input  logic             step,
`endif
  mcpu_if.master           bus,
  output logic             halted,
  output logic [WIDTH-1:0] dbg_pc,
  output logic [WIDTH-1:0] dbg_ir,
  output logic [2:0]       dbg_state
);

  localparam int RW     = reg_idx_w(NREGS);
  localparam int RD_LSB = rd_lsb(WIDTH, NREGS);
  localparam int RS_LSB = rs_lsb(WIDTH, NREGS);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ir;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_z;
  logic             r_c;

  opcode_e          w_op;
  logic [RW-1:0]    w_rd;
  logic [RW-1:0]    w_rs;
  logic             w_acc;
  logic             w_jump_take;
  logic             w_fetch_en;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_z;
  logic             w_alu_c;

  assign w_op        = opcode_e'(r_ir[WIDTH-1 -: OPC_W]);
  assign w_rd        = r_ir[RD_LSB +: RW];
  assign w_rs        = r_ir[RS_LSB +: RW];
  assign w_acc       = (~bus.mem_rd_n | ~bus.mem_wr_n) & bus.mem_ready;
  assign w_jump_take = (w_op == OP_JMP) || ((w_op == OP_JZ) && r_z) ||
                       ((w_op == OP_JC) && r_c);

  mcpu_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (w_op),
    .a      (r_regs[w_rd]),
    .b      (r_regs[w_rs]),
    .c_in   (r_c),
    .result (w_alu_res),
    .z      (w_alu_z),
    .c      (w_alu_c)
  );

`ifdef MCPU_STEP_EN
  logic r_step_q;
  logic r_armed;
  logic w_step_edge;

  assign w_step_edge = step & ~r_step_q;
  assign w_fetch_en  = run | r_armed;

  // Arm one instruction per step edge seen while idle in FETCH; edges at other times are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_q <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_step_q <= step;
      if ((r_state == ST_FETCH) && w_acc) begin
        r_armed <= 1'b0;
      end else if ((r_state == ST_FETCH) && w_step_edge) begin
        r_armed <= 1'b1;
      end
    end
  end
`else
  assign w_fetch_en = 1'b1;
`endif

  // Next-state and bus strobes, decoded from the current state.
  always_comb begin
    w_state_nxt   = r_state;
    bus.mem_addr  = r_pc;
    bus.mem_wdata = r_regs[w_rs];
    bus.mem_rd_n  = 1'b1;
    bus.mem_wr_n  = 1'b1;
    case (r_state)
      ST_FETCH: begin
        if (w_fetch_en) begin
          bus.mem_rd_n = 1'b0;
          if (bus.mem_ready) w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_op == OP_NOP)        w_state_nxt = ST_FETCH;
        else if (w_op == OP_HLT)   w_state_nxt = ST_HALT;
        else if (is_two_word(w_op)) w_state_nxt = ST_OPND;
        else                       w_state_nxt = ST_EXEC;
      end
      ST_OPND: begin
        bus.mem_rd_n = 1'b0;
        if (bus.mem_ready) begin
          w_state_nxt = ((w_op == OP_LD) || (w_op == OP_ST)) ? ST_MEM : ST_FETCH;
        end
      end
      ST_MEM: begin
        bus.mem_addr = r_opnd;
        if (w_op == OP_ST) bus.mem_wr_n = 1'b0;
        else               bus.mem_rd_n = 1'b0;
        if (bus.mem_ready) w_state_nxt = ST_FETCH;
      end
      ST_EXEC:  w_state_nxt = ST_FETCH;
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Datapath: PC, IR, operand latch, register file and flags update on completed accesses/EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_ir   <= '0;
      r_opnd <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_acc) begin
            r_ir <= bus.mem_rdata;
            r_pc <= r_pc + 1'b1;
          end
        end
        ST_OPND: begin
          if (w_acc) begin
            r_opnd <= bus.mem_rdata;
            r_pc   <= w_jump_take ? bus.mem_rdata : r_pc + 1'b1;
            if (w_op == OP_LDI) r_regs[w_rd] <= bus.mem_rdata;
          end
        end
        ST_MEM: begin
          if (w_acc && (w_op == OP_LD)) r_regs[w_rd] <= bus.mem_rdata;
        end
        ST_EXEC: begin
          r_regs[w_rd] <= w_alu_res;
          r_z          <= w_alu_z;
          r_c          <= w_alu_c;
        end
        default: ;
      endcase
    end
  end

  assign halted    = (r_state == ST_HALT);
  assign dbg_pc    = r_pc;
  assign dbg_ir    = r_ir;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mcpu_core.sv
// Self-checking bench for mcpu_core: table of programs on an 8-bit core plus a 12-bit instance.
// Latency: programs run to HALT under bounded cycle budgets.
// Backpressure: memory model inserts random wait states and can stall an access indefinitely.
module tb_mcpu_core;
  import mcpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- 8-bit DUT ----------------
  mcpu_if #(.WIDTH(8))  bus8 ();
  mcpu_if #(.WIDTH(12)) bus12 ();
  logic        halted8, halted12;
  logic [7:0]  pc8, ir8;
  logic [11:0] pc12, ir12;
  logic [2:0]  st8, st12;
`ifdef MCPU_STEP_EN
  logic run  = 1'b1;
  logic step = 1'b0;
  logic run12  = 1'b1;
  logic step12 = 1'b0;
`endif

  mcpu_core #(.WIDTH(8), .NREGS(4), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MCPU_STEP_EN
    .run       (run),
    .step      (step),
`endif
    .bus       (bus8),
    .halted    (halted8),
    .dbg_pc    (pc8),
    .dbg_ir    (ir8),
    .dbg_state (st8)
  );

  mcpu_core #(.WIDTH(12), .NREGS(8), .RESET_PC(12'hFFC)) dut12 (
    .clk       (clk),
    .rst       (rst),
`ifdef MCPU_STEP_EN
    .run       (run12),
    .step      (step12),
`endif
    .bus       (bus12),
    .halted    (halted12),
    .dbg_pc    (pc12),
    .dbg_ir    (ir12),
    .dbg_state (st12)
  );

  // ---------------- 8-bit memory model ----------------
  logic [7:0] img [256];
  logic [7:0] mem [256];
  int  max_wait    = 0;
  int  wait_left   = 0;
  bit  force_stall = 1'b0;
  int  writes      = 0;

  assign bus8.mem_rdata = mem[bus8.mem_addr];
  assign bus8.mem_ready = !force_stall && (wait_left == 0);

  // RAM: reloads the image during reset, counts down wait states, commits writes on ready.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      wait_left <= int'($urandom_range(max_wait, 0));
      writes    <= 0;
    end else if (!bus8.mem_rd_n || !bus8.mem_wr_n) begin
      if (bus8.mem_ready) begin
        if (!bus8.mem_wr_n) begin
          mem[bus8.mem_addr] <= bus8.mem_wdata;
          writes <= writes + 1;
        end
        wait_left <= int'($urandom_range(max_wait, 0));
      end else if (wait_left > 0) begin
        wait_left <= wait_left - 1;
      end
    end
  end

  logic       p_wait = 1'b0;
  logic [7:0] p_addr, p_wdata;
  logic       p_rd, p_wr;
  int         stab_err   = 0;
  int         waits_seen = 0;

  // Bus must not move while an access is being held off by mem_ready=0.
  always @(negedge clk) begin
    if (rst) begin
      p_wait <= 1'b0;
    end else begin
      if (p_wait && ((bus8.mem_addr != p_addr) || (bus8.mem_rd_n != p_rd) ||
                     (bus8.mem_wr_n != p_wr) || (!p_wr && (bus8.mem_wdata != p_wdata))))
        stab_err <= stab_err + 1;
      p_wait  <= (!bus8.mem_rd_n || !bus8.mem_wr_n) && !bus8.mem_ready;
      if ((!bus8.mem_rd_n || !bus8.mem_wr_n) && !bus8.mem_ready) waits_seen <= waits_seen + 1;
      if (!bus8.mem_rd_n && !bus8.mem_wr_n) stab_err <= stab_err + 1;
      p_addr  <= bus8.mem_addr;
      p_wdata <= bus8.mem_wdata;
      p_rd    <= bus8.mem_rd_n;
      p_wr    <= bus8.mem_wr_n;
    end
  end

  // ---------------- 12-bit ROM and write capture ----------------
  function automatic logic [11:0] rom12(input logic [11:0] a);
    case (a)
      12'hFFC: return 12'h1A0;  // LDI r5
      12'hFFD: return 12'h800;
      12'hFFE: return 12'hAA0;  // SHL r5
      12'hFFF: return 12'hD00;  // JZ (operand sits at 0x000 after wrap)
      12'h000: return 12'h005;
      12'h005: return 12'h314;  // ST r5,[0x100]
      12'h006: return 12'h100;
      12'h007: return 12'hE00;  // JC 0x00A
      12'h008: return 12'h00A;
      default: return 12'hF00;  // HLT
    endcase
  endfunction

  assign bus12.mem_rdata = rom12(bus12.mem_addr);
  assign bus12.mem_ready = 1'b1;

  int          w12_cnt  = 0;
  logic [11:0] w12_addr = '0;
  logic [11:0] w12_data = '0;
  bit          seen_wrap = 1'b0;

  // Capture stores from the 12-bit core.
  always @(posedge clk) begin
    if (rst) begin
      w12_cnt  <= 0;
      w12_addr <= 12'h000;
      w12_data <= 12'hFFF;
    end else if (!bus12.mem_wr_n) begin
      w12_cnt  <= w12_cnt + 1;
      w12_addr <= bus12.mem_addr;
      w12_data <= bus12.mem_wdata;
    end
  end

  // Note when the 12-bit PC has wrapped to zero.
  always @(negedge clk) begin
    if (rst) seen_wrap <= 1'b0;
    else if (pc12 == 12'h000) seen_wrap <= 1'b1;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string        name;
    logic [127:0] prog;
    int           mw;
    logic [7:0]   exp_pc;
    logic [7:0]   exp_m80;
    int           exp_wr;
    int           exp_cyc;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [127:0] p, input int mw,
                              input logic [7:0] pc, input logic [7:0] m80,
                              input int wr, input int cyc);
    vec_t v;
    v.name = n; v.prog = p; v.mw = mw; v.exp_pc = pc;
    v.exp_m80 = m80; v.exp_wr = wr; v.exp_cyc = cyc;
    return v;
  endfunction

  task automatic load_img(input logic [127:0] p);
    for (int i = 0; i < 256; i++) img[i] = (i < 16) ? p[127 - 8*i -: 8] : 8'hF0;
    img[8'h80] = 8'hAA;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halted8 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  vec_t vt [6];

  initial begin
    int cyc;

    vt[0] = mk("basic",      128'h10051403_413080F0_F0F0F0F0_F0F0F0F0, 0, 8'h08, 8'h08, 1, 15);
    vt[1] = mk("basic_wait", 128'h10051403_413080F0_F0F0F0F0_F0F0F0F0, 3, 8'h08, 8'h08, 1, -1);
    vt[2] = mk("add_jz",     128'h10FF1401_41D00AF0_00003080_E010F000, 0, 8'h11, 8'h00, 1, -1);
    vt[3] = mk("sub_jz",     128'h10031405_51D02030_80E00CF0_F0F0F0F0, 1, 8'h0D, 8'hFE, 1, -1);
    vt[4] = mk("logic",      128'h10C5143C_81B090A0_61713080_E020F0F0, 2, 8'h0F, 8'h3C, 1, -1);
    vt[5] = mk("ld_st",      128'h280E3280_00F0F0F0_F0F0F0F0_F0F05AF0, 0, 8'h06, 8'h5A, 1, 12);

    // Reset state and first fetch strobe.
    load_img(vt[0].prog);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.state",  st8, 32'd0);
    chk("rst.halted", halted8, 32'd0);
    chk("rst.ir",     ir8, 32'h00);
    chk("rst.rd_n",   bus8.mem_rd_n, 32'd0);
    chk("rst.wr_n",   bus8.mem_wr_n, 32'd1);
    chk("rst.addr",   bus8.mem_addr, 32'h00);
    chk("rst.pc12",   pc12, 32'hFFC);

    // Table of programs run to HALT.
    for (int k = 0; k < 6; k++) begin
      load_img(vt[k].prog);
      max_wait = vt[k].mw;
      do_reset();
      run_to_halt(cyc);
      chk($sformatf("%s.halted", vt[k].name), halted8, 32'd1);
      chk($sformatf("%s.pc", vt[k].name), pc8, {24'd0, vt[k].exp_pc});
      chk($sformatf("%s.mem80", vt[k].name), mem[8'h80], {24'd0, vt[k].exp_m80});
      chk($sformatf("%s.writes", vt[k].name), writes, vt[k].exp_wr);
      if (vt[k].exp_cyc >= 0)
        chk($sformatf("%s.cycles", vt[k].name), cyc, vt[k].exp_cyc);
      repeat (3) @(negedge clk);
      chk($sformatf("%s.halt_strobes", vt[k].name),
          {bus8.mem_rd_n, bus8.mem_wr_n}, 32'd3);
    end
    chk("wait.stable_err", stab_err, 32'd0);
    chk("wait.seen", (waits_seen > 0), 32'd1);

    // Reset during a stalled LD.
    load_img(vt[5].prog);
    max_wait = 0;
    do_reset();
    cyc = 0;
    while (st8 != 3'd3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    force_stall = 1'b1;
    chk("stall.reached", st8, 32'd3);
    repeat (3) @(negedge clk);
    chk("stall.state", st8, 32'd3);
    chk("stall.rd_n",  bus8.mem_rd_n, 32'd0);
    chk("stall.addr",  bus8.mem_addr, 32'h0E);
    chk("stall.pc",    pc8, 32'h02);
    load_img(128'h3280F0F0_F0F0F0F0_F0F0F0F0_F0F0F0F0);
    rst = 1'b1;
    @(negedge clk);
    chk("stall_rst.rd_n",  bus8.mem_rd_n, 32'd0);
    chk("stall_rst.addr",  bus8.mem_addr, 32'h00);
    chk("stall_rst.state", st8, 32'd0);
    force_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_to_halt(cyc);
    chk("stall_rst.r2", mem[8'h80], 32'h00);
    chk("stall_rst.pc", pc8, 32'h03);

    // 12-bit / 8-register instance: SHL carry-out and PC wrap.
    do_reset();
    cyc = 0;
    while (!halted12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("w12.halted", halted12, 32'd1);
    chk("w12.pc",     pc12, 32'h00B);
    chk("w12.wrap",   seen_wrap, 32'd1);
    chk("w12.writes", w12_cnt, 32'd1);
    chk("w12.waddr",  w12_addr, 32'h100);
    chk("w12.wdata",  w12_data, 32'h000);

`ifdef MCPU_STEP_EN
    // Single-step: three step pulses execute exactly three instructions.
    begin
      logic [7:0] exp_step_pc [3];
      exp_step_pc[0] = 8'h02;
      exp_step_pc[1] = 8'h04;
      exp_step_pc[2] = 8'h05;
      load_img(vt[0].prog);
      max_wait = 0;
      run = 1'b0;
      do_reset();
      repeat (5) @(negedge clk);
      chk("step.idle_pc",   pc8, 32'h00);
      chk("step.idle_rd_n", bus8.mem_rd_n, 32'd1);
      for (int k = 0; k < 3; k++) begin
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (12) @(negedge clk);
        chk($sformatf("step%0d.pc", k), pc8, {24'd0, exp_step_pc[k]});
        repeat (5) @(negedge clk);
        chk($sformatf("step%0d.frozen", k), pc8, {24'd0, exp_step_pc[k]});
      end
      chk("step.final_state", st8, 32'd0);
      run = 1'b1;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mcpu_core.md
Name: mcpu_core

Overview:
- Parametrised multi-cycle accumulator/register CPU core. Successor to the fixed 8-bit, one-hot-microword datapath.
- Generalised data/address width and register count. Encoded FSM replaces the phase-counter control. Adds ready-handshaked memory accesses (wait states), Z/C flags and conditional jumps.
- Sits between the board-level top (LEDs, switches) and an external single-port RAM on a shared bidirectional-free split bus.

Parameters:
WIDTH, 8, data and address width in bits; must satisfy WIDTH >= 4 + 2*log2(NREGS)
NREGS, 4, general registers r0..r(NREGS-1); power of two, >= 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
mem_addr  out  WIDTH  memory address
mem_wdata  out  WIDTH  store data, valid while mem_wr_n=0
mem_rdata  in  WIDTH  load/fetch data, sampled when mem_ready=1
mem_rd_n  out  1  read strobe, active-low
mem_wr_n  out  1  write strobe, active-low
mem_ready  in  1  access completes on a cycle where a strobe is low and mem_ready=1
halted  out  1  high in HALT state
dbg_pc  out  WIDTH  current PC
dbg_ir  out  WIDTH  current instruction register
dbg_state  out  3  FSM state encoding

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: pc=RESET_PC, ir=0, all regs=0, Z=C=0, state=FETCH, halted=0.
  - Strobes are decoded combinationally from state, so mem_rd_n=0 with mem_addr=RESET_PC in the first cycle after reset.
- Instruction word: [WIDTH-1:WIDTH-4] opcode; next RW=log2(NREGS) bits rd; next RW bits rs; rest ignored.
- Opcodes:
  - 0 NOP
  - 1 LDI rd,#imm (2 words)
  - 2 LD rd,[a] (2 words)
  - 3 ST rs,[a] (2 words)
  - 4 ADD rd,rs
  - 5 SUB
  - 6 AND
  - 7 OR
  - 8 XOR
  - 9 NOT rd
  - A SHL rd
  - B SHR rd
  - C JMP a
  - D JZ a
  - E JC a
  - F HLT
- States and transitions:
  - FETCH: rd strobe at pc. On ready: ir<=rdata, pc<=pc+1, go to DECODE.
  - DECODE (1 cycle):
    - NOP -> FETCH
    - ALU ops -> EXEC
    - two-word ops -> OPND
    - HLT -> HALT
  - OPND: rd strobe at pc. On ready: opnd<=rdata, pc<=pc+1. Then:
    - LDI: rd<=rdata -> FETCH
    - JMP, or JZ with Z=1, or JC with C=1: pc<=rdata -> FETCH
    - untaken jump: pc advances only -> FETCH
    - LD/ST -> MEM
  - MEM: mem_addr=opnd.
    - LD: rd strobe; on ready rd<=rdata.
    - ST: wr strobe, mem_wdata=regs[rs].
    - Either way, on ready -> FETCH.
  - EXEC (1 cycle): rd<=result, update flags -> FETCH.
  - HALT: terminal; both strobes high; left only by rst.
- Flags (set only in EXEC; LD/LDI/jumps leave Z/C unchanged):
  - Z = (result==0) for all ALU ops.
  - ADD: C = carry out.
  - SUB: C = borrow (rd < rs unsigned).
  - AND/OR/XOR/NOT: C = 0.
  - SHL: C = old msb. SHR: C = old lsb; zero fill.
- Arithmetic is modulo 2^WIDTH. pc wraps from all-ones to 0 without error.
- At most one strobe is low in any cycle. Strobes are never low in DECODE, EXEC or HALT.
- mem_ready: ignored when no strobe is active. Any number of wait cycles are allowed. mem_addr/mem_wdata/strobes are held stable while waiting.
- Zero-wait cycle counts:
  - NOP: 2 cycles
  - ALU ops: 3 cycles
  - LDI/JMP: 3 cycles
  - LD/ST: 4 cycles
- rst asserted mid-access (including during wait states): the access is abandoned at that edge with no register or flag update, and fetch restarts at RESET_PC.

Optional Feature:
- Macro MCPU_STEP_EN adds input ports run (1) and step (1).
  - When run=0, the core waits in FETCH with strobes high until a rising edge of step is detected (registered edge detect). It then executes exactly one instruction.
  - When run=1, the core free-runs.
  - A step edge arriving while an instruction is in progress is dropped.
- Without the macro, the ports are absent and the core always free-runs.

Decomposition:
- Package mcpu_pkg:
  - opcode constants
  - FSM state encoding (FETCH=0, DECODE=1, OPND=2, MEM=3, EXEC=4, HALT=5)
  - field-position helper constants derived from WIDTH/NREGS
- Sub-module mcpu_alu: combinational. Inputs: op, a, b, c_in. Outputs: result, z, c. Parametrised by WIDTH.
- The register file and FSM stay in mcpu_core.

Test Plan:
- Basic program, mem_ready tied 1. Program: 0x10 0x05, 0x14 0x03, 0x41, 0x30 0x80, 0xF0. Required: mem[0x80]=0x08, halted=1, dbg_pc=0x08, exactly one write strobe.
- Random 0-3 wait states on every access, same program. Required: identical result; addr/wdata/strobes stable during each wait.
- Flags and conditional jumps: ADD of 0xFF+0x01 -> r=0x00, Z=1, C=1; JZ taken to target. SUB 3-5 -> 0xFE, C=1, Z=0; JZ not taken, pc advances by 2.
- Reset during a stalled LD (mem_ready held 0): assert rst. Required: destination register unchanged from reset value 0, next strobe is a read at address 0x00.
- Parametrisation, WIDTH=12, NREGS=8: SHL of 0x800 -> 0x000, C=1, Z=1; pc wraps from 0xFFF to 0x000.
- MCPU_STEP_EN, run=0: three step pulses execute exactly three instructions. dbg_pc is frozen between pulses.
